a_rom_read: RTL and testbench

Reader for the packed coefficient-matrix A memory. Once the loader has filled all 16 words and raised its done flag, and a start pulse arrives, this block reads the memory in address order and unpacks each 14-bit word into two 7-bit coefficients. It streams the 32 coefficients of the 8×4 matrix, column-major, to the matrix-multiply datapath over a valid/ready handshake, tagging each coefficient with its row and column.

---
 rtl/a_rom_read.sv | 151 +++++++++++++++
 tb/tb_a_rom_read.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/a_rom_read.sv
// a_rom_read: streams the packed 8x4 coefficient matrix A out of a 16-word
// memory, two 7-bit coefficients per word, column-major, tagged with row/col.
// Optional build macro A_READ_LOOP_EN: wrap from the last word back to word 0
// and keep streaming forever (DONE never entered).
module a_rom_read #(
    parameter int unsigned COEF_W = 7,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned WORDS  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                aload_done,
    input  logic                start,
    output logic                rd_en,
    output logic [ADDR_W-1:0]   rd_addr,
    input  logic [2*COEF_W-1:0] rd_data,
    output logic [COEF_W-1:0]   coef_out,
    output logic [2:0]          coef_row,
    output logic [1:0]          coef_col,
    output logic                coef_valid,
    input  logic                coef_ready,
    output logic                busy,
    output logic                done
);

    localparam int unsigned DATA_W = 2 * COEF_W;
    localparam int unsigned ROW_W  = 3;
    localparam int unsigned COL_W  = 2;
    localparam int unsigned P_W    = ROW_W - 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_EMIT_HI,
        S_EMIT_LO,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   hold_q, hold_d;
    logic                lo_q, lo_d;
    logic                rd_en_q, rd_en_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                xfer;
    logic                go;

    assign xfer = valid_q && coef_ready;
    assign go   = start && aload_done;

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        hold_d  = hold_q;
        lo_d    = lo_q;

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    addr_d  = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                hold_d  = rd_data;
                lo_d    = 1'b0;
                state_d = S_EMIT_HI;
            end
            S_EMIT_HI: begin
                // Shift the low coefficient into the output half of the hold register
                if (xfer) begin
                    hold_d  = {hold_q[COEF_W-1:0], COEF_W'(0)};
                    lo_d    = 1'b1;
                    state_d = S_EMIT_LO;
                end
            end
            S_EMIT_LO: begin
                if (xfer) begin
                    if (addr_q == LAST_ADDR) begin
`ifdef A_READ_LOOP_EN
                        addr_d  = '0;
                        state_d = S_FETCH;
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                if (go) begin
                    addr_d  = '0;
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        rd_en_d = (state_d == S_FETCH);
        valid_d = (state_d == S_EMIT_HI) || (state_d == S_EMIT_LO);
        busy_d  = (state_d == S_FETCH) || (state_d == S_CAPTURE) ||
                  (state_d == S_EMIT_HI) || (state_d == S_EMIT_LO);
        done_d  = (state_d == S_DONE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            hold_q  <= '0;
            lo_q    <= 1'b0;
            rd_en_q <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            hold_q  <= hold_d;
            lo_q    <= lo_d;
            rd_en_q <= rd_en_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Row/col come straight from the word address: row = {p, half}, col = a[3:2]
    assign rd_en      = rd_en_q;
    assign rd_addr    = addr_q;
    assign coef_out   = hold_q[DATA_W-1:COEF_W];
    assign coef_row   = {addr_q[P_W-1:0], lo_q};
    assign coef_col   = addr_q[P_W +: COL_W];
    assign coef_valid = valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_a_rom_read.sv
// Bench for a_rom_read: behavioural memory, column-major stream model,
// timing/backpressure/reset checks; loop variant under A_READ_LOOP_EN.
`timescale 1ns/1ps
module tb_a_rom_read;

    localparam int unsigned COEF_W = 7;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned WORDS  = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic                aload_done;
    logic                start;
    logic                rd_en;
    logic [ADDR_W-1:0]   rd_addr;
    logic [2*COEF_W-1:0] rd_data;
    logic [COEF_W-1:0]   coef_out;
    logic [2:0]          coef_row;
    logic [1:0]          coef_col;
    logic                coef_valid;
    logic                coef_ready;
    logic                busy;
    logic                done;

    a_rom_read #(.COEF_W(COEF_W), .ADDR_W(ADDR_W), .WORDS(WORDS)) dut (
        .clk        (clk),
        .rst        (rst),
        .aload_done (aload_done),
        .start      (start),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .coef_out   (coef_out),
        .coef_row   (coef_row),
        .coef_col   (coef_col),
        .coef_valid (coef_valid),
        .coef_ready (coef_ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous memory: data valid one cycle after rd_en
    logic [2*COEF_W-1:0] mem [WORDS];
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    int n_tests = 0;
    int n_fail  = 0;
    bit dir_vals = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] obs();
        return {coef_out, coef_row, coef_col};
    endfunction

    function automatic logic [19:0] all_outs();
        return {rd_en, rd_addr, coef_out, coef_row, coef_col, coef_valid, busy, done};
    endfunction

    // Coefficient k of the column-major 8x4 stream, taken from the memory image
    function automatic logic [11:0] model(input int k);
        int kk  = k % 32;
        int col = kk / 8;
        int row = kk % 8;
        int w   = col * 4 + row / 2;
        logic [13:0] word = mem[w];
        logic [6:0]  v    = (row % 2 == 0) ? word[13:7] : word[6:0];
        return {v, 3'(row), 2'(col)};
    endfunction

    task automatic load_formula();
        for (int a = 0; a < int'(WORDS); a++) mem[a] = {7'(2 * a + 1), 7'(2 * a + 2)};
    endtask

    task automatic load_random();
        for (int a = 0; a < int'(WORDS); a++) mem[a] = 14'($urandom);
    endtask

    // mode 0: ready high (stray start at offset 10); 1: 3-cycle stall on row3/col1;
    // 2: random ready, aload_done and starts while busy. abort: reset during word 5 low half.
    task automatic run_pass(input int mode, input bit abort, input string nm);
        int s, off, stalls, bp_left, first_v, last_x, done_o, k;
        bit prev_stall;
        logic [11:0] saved;
        k = 0; stalls = 0; bp_left = 3; first_v = -1; last_x = -1; done_o = -1;
        prev_stall = 1'b0; saved = '0;
        aload_done = 1'b1; start = 1'b1; coef_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        s = int'(cyc);
        check_eq({nm, "_rd_en_n1"}, 32'(rd_en), 32'd1);
        check_eq({nm, "_rd_addr_n1"}, 32'(rd_addr), 32'd0);
        check_eq({nm, "_done_n1"}, 32'(done), 32'd0);
        for (int g = 0; g < 400; g++) begin
            off = int'(cyc) - s + 1;
            if (done) begin
                done_o = off;
                break;
            end
            coef_ready = 1'b1;
            if (mode == 1) begin
                if (coef_valid && coef_row == 3'd3 && coef_col == 2'd1 && bp_left > 0) begin
                    coef_ready = 1'b0;
                    bp_left--;
                end
            end else if (mode == 2) begin
                coef_ready = ($urandom_range(3) != 0);
                aload_done = 1'($urandom_range(1));
                start      = busy && ($urandom_range(7) == 0);
            end
            if (mode == 0 && off == 10) begin
                check_eq({nm, "_busy_at10"}, 32'(busy), 32'd1);
                start = 1'b1;
            end else if (mode != 2) begin
                start = 1'b0;
            end
            if (prev_stall)
                check_eq({nm, "_stable"}, 32'({coef_valid, obs()}), 32'({1'b1, saved}));
            if (coef_valid && first_v < 0) first_v = off;
            if (abort && coef_valid && k == 11) begin
                rst = 1'b1; coef_ready = 1'b0; start = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                check_eq({nm, "_outs_zero"}, 32'(all_outs()), 32'd0);
                aload_done = 1'b1; coef_ready = 1'b1;
                return;
            end
            if (coef_valid && coef_ready) begin
                check_eq({nm, "_coef"}, 32'(obs()), 32'(model(k)));
                if (dir_vals) check_eq({nm, "_value"}, 32'(coef_out), 32'(k + 1));
                k++;
                last_x = off;
            end
            if (coef_valid && !coef_ready) stalls++;
            prev_stall = coef_valid && !coef_ready;
            saved = obs();
            @(negedge clk);
        end
        start = 1'b0; aload_done = 1'b1; coef_ready = 1'b1;
        check_eq({nm, "_count"}, 32'(k), 32'd32);
        check_eq({nm, "_first_valid"}, 32'(first_v), 32'd3);
        check_eq({nm, "_last_xfer"}, 32'(last_x), 32'(64 + stalls));
        check_eq({nm, "_done_at"}, 32'(done_o), 32'(65 + stalls));
    endtask

    task automatic run_loop();
        int k, done_seen;
        logic [11:0] first, c33;
        k = 0; done_seen = 0; first = '0; c33 = '1;
        aload_done = 1'b1; start = 1'b1; coef_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int g = 0; g < 200; g++) begin
            if (done) done_seen++;
            if (coef_valid) begin
                check_eq("loop_coef", 32'(obs()), 32'(model(k)));
                if (k == 0) first = obs();
                if (k == 32) c33 = obs();
                k++;
            end
            @(negedge clk);
        end
        check_eq("loop_done_low", 32'(done_seen), 32'd0);
        check_eq("loop_busy", 32'(busy), 32'd1);
        check_eq("loop_c33_model", 32'(c33), 32'(model(0)));
        check_eq("loop_c33_eq_c1", 32'(c33), 32'(first));
    endtask

    initial begin
        rst = 1'b1; aload_done = 1'b0; start = 1'b0; coef_ready = 1'b0; rd_data = '0;
        load_formula();
        repeat (3) @(negedge clk);
        check_eq("reset_outs", 32'(all_outs()), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("idle_outs", 32'(all_outs()), 32'd0);

        // start without aload_done is ignored
        mem[0] = 14'h0081;
        aload_done = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_eq("no_load_idle", 32'({rd_en, busy, done}), 32'd0);
            @(negedge clk);
        end
        load_formula();

`ifdef A_READ_LOOP_EN
        run_loop();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("loop_reset_outs", 32'(all_outs()), 32'd0);
`else
        dir_vals = 1'b1;
        run_pass(0, 1'b0, "pass");
        dir_vals = 1'b0;
        @(negedge clk);
        check_eq("done_hold", 32'({done, busy, coef_valid}), 32'b100);
        check_eq("done_addr", 32'(rd_addr), 32'd15);
        run_pass(1, 1'b0, "bp");
        for (int r = 0; r < 3; r++) begin
            load_random();
            run_pass(2, 1'b0, "rnd");
        end
        load_random();
        run_pass(0, 1'b1, "abort");
        run_pass(0, 1'b0, "after_abort");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
